// File: rtl/sram_controller.sv
// Bridges one 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM
// as two half-word accesses (low then high), freezing the pipeline meanwhile.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_ce_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } stateT;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  stateT       state;
  stateT       stateNext;
  logic [3:0]  cnt;
  logic [3:0]  cntNext;
  logic        opWrite;
  logic        opWriteNext;
  logic        req;
  logic        lastCycle;
  logic [31:0] eff;
  logic        unusedEffBits;

  assign req           = rd_en | wr_en;
  assign eff           = address - BASE_ADDR;
  assign lastCycle     = (cnt == LAST_CNT);
  assign ready         = ~req | (state == DONE);
  assign unusedEffBits = ^{eff[31:19], eff[1:0]};

  // State, phase counter, latched op and load data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      opWrite <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      opWrite <= opWriteNext;
      if (!opWrite && lastCycle) begin
        if (state == LOW) begin
          rdata[15:0] <= sram_dq_in;
        end else if (state == HIGH) begin
          rdata[31:16] <= sram_dq_in;
        end
      end
    end
  end

  // Next-state logic; the op is latched only in IDLE so mid-transfer
  // changes on rd_en/wr_en cannot redirect an access in flight
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    opWriteNext = opWrite;
    case (state)
      IDLE: begin
        cntNext = 4'd0;
        if (req) begin
          opWriteNext = wr_en;
          stateNext   = LOW;
        end
      end
      LOW: begin
        if (lastCycle) begin
          cntNext   = 4'd0;
          stateNext = HIGH;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (lastCycle) begin
          cntNext   = 4'd0;
          stateNext = DONE;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end
      DONE: begin
        cntNext   = 4'd0;
        stateNext = IDLE;
      end
      default: begin
        cntNext   = 4'd0;
        stateNext = IDLE;
      end
    endcase
  end

  // SRAM bus drive; we_n is released on the last cycle of each phase so
  // address and data are held stable across the rising edge of we_n
  always_comb begin
    sram_ce_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    if (state == LOW || state == HIGH) begin
      sram_ce_n = 1'b0;
      sram_addr = {eff[18:2], (state == HIGH)};
      if (opWrite) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = lastCycle;
        sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM plus a word-level
// reference memory, cycle-by-cycle bus checks and randomized load/store traffic.
module tb_sram_controller;

  localparam int          A      = 2;
  localparam logic [31:0] BASE   = 32'd1024;
  localparam int          PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_ce_n;

  logic [15:0] sramMem [0:262143];
  logic        preloadEn = 1'b0;
  logic [17:0] preloadAddr = 18'd0;
  logic [15:0] preloadData = 16'd0;

  logic [31:0] refMem [int];
  logic [31:0] expRdata = 32'd0;
  int          testsRun = 0;
  int          testsFailed = 0;
  time         lastReadyTime = 0;
  time         prevReadyTime = 0;

  sram_controller #(.ACCESS_CYCLES(A), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_ce_n  (sram_ce_n)
  );

  always #(PERIOD / 2) clk = ~clk;

  // Asynchronous SRAM model: combinational read, write committed while we_n is low
  assign sram_dq_in = sramMem[sram_addr];
  always @(posedge clk) begin
    if (preloadEn) begin
      sramMem[preloadAddr] <= preloadData;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      sramMem[sram_addr] <= sram_dq_out;
    end
  end

  initial begin
    #(PERIOD * 20000);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] refGet(input int idx);
    return refMem.exists(idx) ? refMem[idx] : 32'd0;
  endfunction

  task automatic preloadHalf(input logic [17:0] a, input logic [15:0] d);
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = d;
    @(posedge clk);
    #1;
    preloadEn = 1'b0;
  endtask

  // One full transfer, checked every cycle against spec-derived bus values
  task automatic doTransfer(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int dropAt, input string tag);
    logic [31:0] eff;
    logic [16:0] idx;
    logic        reqNow;
    logic [31:0] newRdata;
    logic        active;
    logic        half;
    int          k;
    logic [37:0] expBus;
    logic [37:0] actBus;
    eff      = addr - BASE;
    idx      = eff[18:2];
    newRdata = (!wr) ? refGet(int'(idx)) : expRdata;
    rd_en    = rd;
    wr_en    = wr;
    address  = addr;
    wdata    = wd;
    reqNow   = rd | wr;
    for (int c = 0; c <= 2 * A + 1; c++) begin
      if (c == dropAt) begin
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        reqNow = 1'b0;
      end
      @(negedge clk);
      active = (c >= 1) && (c <= 2 * A);
      half   = (c > A);
      k      = (c - 1) % A;
      expBus[37]    = !active;
      expBus[36]    = active && wr;
      expBus[35]    = !(active && wr && (k != A - 1));
      expBus[34]    = !reqNow || (c == 2 * A + 1);
      expBus[33:16] = active ? {idx, half} : 18'd0;
      expBus[15:0]  = (active && wr) ? (half ? wd[31:16] : wd[15:0]) : 16'd0;
      actBus = {sram_ce_n, sram_dq_oe, sram_we_n, ready, sram_addr, sram_dq_out};
      testsRun++;
      if (actBus !== expBus) begin
        testsFailed++;
        $display("[TB] FAIL %s bus cycle %0d: got ce/oe/we/rdy/addr/dq=%b/%b/%b/%b/%h/%h, required %b/%b/%b/%b/%h/%h",
                 tag, c, actBus[37], actBus[36], actBus[35], actBus[34], actBus[33:16], actBus[15:0],
                 expBus[37], expBus[36], expBus[35], expBus[34], expBus[33:16], expBus[15:0]);
      end
      if (c == 0 || c == 2 * A + 1) begin
        testsRun++;
        if (rdata !== ((c == 0) ? expRdata : newRdata)) begin
          testsFailed++;
          $display("[TB] FAIL %s rdata cycle %0d: got %h, required %h", tag, c, rdata,
                   (c == 0) ? expRdata : newRdata);
        end
      end
      if (c == 2 * A + 1 && ready) begin
        prevReadyTime = lastReadyTime;
        lastReadyTime = $time;
      end
      @(posedge clk);
      #1;
    end
    if (wr) refMem[int'(idx)] = wd;
    expRdata = newRdata;
  endtask

  task automatic idleCycles(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      testsRun++;
      if (ready !== 1'b1 || sram_ce_n !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL idle: got rdy/ce/we/oe=%b/%b/%b/%b, required 1/1/1/0",
                 ready, sram_ce_n, sram_we_n, sram_dq_oe);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    address = 32'd0;
    wdata   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if ({ready, sram_ce_n, sram_we_n, sram_dq_oe} !== 4'b1110 || rdata !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset: got rdy/ce/we/oe=%b/%b/%b/%b rdata=%h, required 1/1/1/0 rdata=0",
               ready, sram_ce_n, sram_we_n, sram_dq_oe, rdata);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    idleCycles(2);
  endtask

  task automatic test_load();
    preloadHalf(18'd4, 16'h5678);
    preloadHalf(18'd5, 16'h1234);
    refMem[2] = 32'h12345678;
    doTransfer(1'b1, 1'b0, 32'd1032, 32'h0, -1, "load");
    testsRun++;
    if (expRdata !== 32'h12345678) begin
      testsFailed++;
      $display("[TB] FAIL load model: got %h, required 12345678", expRdata);
    end
    idleCycles(1);
  endtask

  task automatic test_store();
    doTransfer(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, -1, "store");
    idleCycles(1);
    doTransfer(1'b1, 1'b0, 32'd1032, 32'h0, -1, "store_readback");
    idleCycles(1);
  endtask

  task automatic test_both();
    doTransfer(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, -1, "both");
    idleCycles(1);
    doTransfer(1'b1, 1'b0, 32'd1040, 32'h0, -1, "both_readback");
    idleCycles(1);
  endtask

  task automatic test_back_to_back();
    doTransfer(1'b0, 1'b1, 32'd1100, 32'hA5A55A5A, -1, "b2b_store");
    doTransfer(1'b1, 1'b0, 32'd1100, 32'h0, -1, "b2b_load");
    testsRun++;
    if (lastReadyTime - prevReadyTime !== time'((2 * A + 2) * PERIOD)) begin
      testsFailed++;
      $display("[TB] FAIL b2b spacing: got %0t, required %0t", lastReadyTime - prevReadyTime,
               time'((2 * A + 2) * PERIOD));
    end
    idleCycles(1);
  endtask

  task automatic test_drop();
    doTransfer(1'b0, 1'b1, 32'd1204, 32'h13579BDF, 2, "drop_store");
    idleCycles(1);
    doTransfer(1'b1, 1'b0, 32'd1204, 32'h0, 3, "drop_load");
    idleCycles(1);
  endtask

  task automatic test_wrap();
    doTransfer(1'b0, 1'b1, BASE - 32'd4, 32'h0F1E2D3C, -1, "wrap_store");
    doTransfer(1'b1, 1'b0, BASE - 32'd3, 32'h0, -1, "wrap_load");
    idleCycles(1);
  endtask

  task automatic test_reset_mid();
    rd_en   = 1'b1;
    wr_en   = 1'b0;
    address = 32'd1032;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    testsRun++;
    if ({ready, sram_ce_n, sram_we_n, sram_dq_oe} !== 4'b1110 || sram_addr !== 18'd0 ||
        rdata !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid: got rdy/ce/we/oe=%b/%b/%b/%b addr=%h rdata=%h, required 1/1/1/0 addr=0 rdata=0",
               ready, sram_ce_n, sram_we_n, sram_dq_oe, sram_addr, rdata);
    end
    rst      = 1'b0;
    expRdata = 32'd0;
    @(posedge clk);
    #1;
    doTransfer(1'b1, 1'b0, 32'd1032, 32'h0, -1, "reset_mid_load");
    idleCycles(1);
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      doTransfer(1'b0, 1'b1, BASE + 32'(i * 4), $urandom, -1, "rand_fill");
    end
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 2);
      a  = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      doTransfer(op != 1, op != 0, a, $urandom, -1, "rand");
      idleCycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_both();
    test_back_to_back();
    test_drop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage controller between the MEM stage and the off-chip 16-bit asynchronous SRAM that holds data memory.
- Accepts one 32-bit load or store per request from the MEM stage and splits it into two 16-bit SRAM accesses (low half, then high half).
- Deasserts `ready` while a transfer is in flight; the top level uses `~ready` as the pipeline freeze.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: cycles per 16-bit SRAM access; legal range 2..15.
- `BASE_ADDR`, default 1024: CPU byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  MEM-stage load request; held until `ready`.
- `wr_en`  in  1  MEM-stage store request; held until `ready`.
- `address`  in  32  CPU byte address (ALU result).
- `wdata`  in  32  store data (Rm value).
- `rdata`  out  32  load data.
- `ready`  out  1  combinational; 0 = freeze pipeline.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  write data to SRAM.
- `sram_dq_in`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  1 = controller drives the DQ bus.
- `sram_we_n`  out  1  active-low write enable.
- `sram_ce_n`  out  1  active-low chip enable.

## Operation
- `req = rd_en | wr_en`.
  - `wr_en` has priority: if both are high, the request is a store and `rdata` is not updated.
- Address mapping:
  - `eff = address - BASE_ADDR` (32-bit wrap).
  - `sram_addr = {eff[18:2], half}`, where half = 0 for the low phase and 1 for the high phase.
  - `eff[1:0]` is ignored.
- FSM states: IDLE, LOW, HIGH, DONE. A 4-bit counter `cnt` counts cycles within a phase.
  - IDLE: SRAM bus inactive. If `req`: latch the op (read/write), go to LOW with `cnt=0`.
  - LOW: `sram_ce_n=0`, half=0.
    - `cnt` increments each cycle.
    - When `cnt==ACCESS_CYCLES-1`: `rdata[15:0] <= sram_dq_in` (read only), `cnt <= 0`, go to HIGH.
  - HIGH: same as LOW with half=1. On the last cycle, `rdata[31:16] <= sram_dq_in` (read only), then go to DONE.
  - DONE: SRAM bus inactive, `ready=1`, go to IDLE unconditionally.
- Write drive during LOW/HIGH:
  - `sram_dq_oe=1`; `sram_dq_out` = `wdata[15:0]` (LOW) or `wdata[31:16]` (HIGH).
  - `sram_we_n=0` for `cnt < ACCESS_CYCLES-1`; `sram_we_n=1` on the last cycle of each phase, for data/address hold.
- Read drive during LOW/HIGH: `sram_dq_oe=0`, `sram_we_n=1`.
- Inactive bus (IDLE, DONE, reset): `sram_ce_n=1`, `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`.
- `ready = ~req | (state==DONE)`.
- `rdata` holds its value until the next read completes its halves. It is never altered by writes.

## Timing
- Reset values: state=IDLE, `cnt=0`, `rdata=0`, SRAM bus inactive. `ready` follows `~req`, so it is 1 with no request.
- Latency: request first seen in IDLE at cycle 0 → `ready=1` in cycle `1+2*ACCESS_CYCLES` (cycle 5 at default), for exactly one cycle.
  - Total 6 cycles per access at default; `ready=0` in cycles 0..4.
- Load data is stable in `rdata` during the DONE cycle, so the MEM/WB register captures it on that edge.
- Back-to-back requests: the cycle after DONE is IDLE. If `req` is still high (new instruction), a new transfer starts. No request is lost or duplicated.
- Request dropped mid-transfer (protocol violation): the transfer still completes; DONE then IDLE.
- `rd_en` and `wr_en` changing while state≠IDLE: ignored; the op latched in IDLE governs.
- `rst` asserted in any state: next edge forces all reset values. A partial write may leave the SRAM half-updated; this is accepted.
- Address wrap: `address < BASE_ADDR` wraps modulo 2^32. Only `eff[18:2]` is used.

## Test plan
- Reset then idle: `rst=1` for 2 cycles, `req=0` → `ready=1`, `sram_ce_n=1`, `sram_we_n=1`, `sram_dq_oe=0`, `rdata=0`.
- Store: `address=1024+8`, `wdata=32'hDEADBEEF`, `wr_en` held.
  - `sram_addr=4` with `dq_out=16'hBEEF` in cycles 1-2, then `sram_addr=5` with `16'hDEAD` in cycles 3-4.
  - `sram_we_n` is 0,1,0,1 over cycles 1-4; `ready=1` only in cycle 5.
- Load with an SRAM model holding 16'h5678 at 4 and 16'h1234 at 5: `rd_en`, `address=1032` → `rdata=32'h12345678`, `ready=1` in cycle 5.
- Simultaneous `rd_en=wr_en=1`: treated as a store; `rdata` is unchanged from its prior value.
- Back-to-back: store then load to the same address with no idle gap → load returns the stored word; the `ready` pulses are 6 cycles apart.
- Reset mid-transfer: assert `rst` in cycle 3 of a load → next cycle state=IDLE, bus inactive, `rdata=0`. A fresh load then completes normally in 6 cycles.
